bs_config_loader: RTL
=====================

# bs_config_loader

Host-side bitstream transmitter for the fabric configuration chain. It accepts configuration bytes over a valid/ready stream, serializes them MSB-first onto the chain's `bs_in`/`config_en` pins, and counts exactly one chain length of shifts. An optional verify pass re-streams the same bytes and compares them against the bits returning on the chain's `bs_out`. It sits between the host/SPI byte source and the configuration shift chain.

## Interface
- `BS_BITS`, 256, configuration chain length in bits; must be a multiple of 8 and at least 8.
- `clk`  in  1  sole clock; the chain shifts on the same edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle command pulse, honoured only in IDLE.
- `verify`  in  1  sampled with `start`; 1 adds a VERIFY pass.
- `in_data`  in  8  configuration byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `cfg_en`  out  1  drives chain `config_en`; registered.
- `cfg_bit`  out  1  drives chain `bs_in`; registered.
- `cfg_ret`  in  1  chain `bs_out`, i.e. its last stage.
- `busy`  out  1  high in LOAD or VERIFY.
- `done`  out  1  one-cycle pulse when the final shift completes.
- `error`  out  1  sticky verify mismatch; cleared by the next accepted `start`.

## Operation
- States: IDLE, LOAD, VERIFY.
- IDLE: `start` latches `verify`, clears `error` and the bit counter, then goes to LOAD. `start` outside IDLE is ignored.
- LOAD and VERIFY each issue exactly BS_BITS shifts, i.e. BS_BITS/8 bytes.
- Each pass uses the same byte path:
  - A 1-byte holding register feeds an 8-bit shift register.
  - `in_ready` = state is LOAD or VERIFY, AND the holding register is empty, AND the bytes accepted this pass < BS_BITS/8.
- Shift cycle: while the shift register holds bits, assert `cfg_en`=1 and put the current MSB on `cfg_bit`. One bit per cycle.
- When the shift register empties, reload it from the holding register in the same cycle. A host sending one byte every 8 cycles or faster gives gap-free shifting.
- Starvation: if no byte is available, `cfg_en`=0 and the chain holds. Gaps are legal and do not affect the count.
- After the BS_BITS-th shift of LOAD:
  - `verify`=1: go to VERIFY.
  - `verify`=0: go to IDLE and pulse `done`.
- VERIFY: the host resends the identical byte sequence. On every cycle with `cfg_en`=1, compare `cfg_ret` with `cfg_bit`. Any difference sets `error`.
- Why the compare works: the chain is exactly BS_BITS deep, so VERIFY shift k pops LOAD shift k.
- VERIFY leaves the chain holding the same configuration. After its BS_BITS-th shift, go to IDLE and pulse `done`.
- Bit counter width is $clog2(BS_BITS+1). It saturates at BS_BITS, so no wrap-around.
- Bytes offered after the pass quota are not accepted: `in_ready` stays 0.
- Reset, including mid-pass, clears:
  - state to IDLE;
  - `cfg_en`, `cfg_bit`, `busy`, `done`, `error`, `in_ready` to 0;
  - holding and shift registers to empty.
- Chain contents after a mid-pass reset are undefined. The host must restart the load.

## Timing
- A `start` pulse in cycle t gives `busy`=1 and `in_ready`=1 in cycle t+1.
- A byte accepted in cycle t with an empty shift register puts its MSB on `cfg_bit` with `cfg_en`=1 in cycle t+1. The LSB appears in t+8.
- The holding register refills in the same cycle the shift register reloads. `in_ready` returns at t+1 after that reload.
- `done` is high in the cycle after the last `cfg_en`=1 cycle. `busy` falls in that same cycle.
- `error` updates one cycle after the mismatching shift cycle.
- Minimum full load is BS_BITS+2 cycles from `start` to `done`. With verify it is 2·BS_BITS+2, assuming no gaps.

## Structure
- Package `bs_cfg_pkg`:
  - state enum `bs_state_t` (IDLE, LOAD, VERIFY);
  - `BS_BYTE_W`=8;
  - function `bs_cnt_w(bits)` returning $clog2(bits+1).
- Sub-module `bs_byte_serializer`: holding register, 8-bit shift register, `in_ready` logic, `cfg_en`/`cfg_bit` registers, and a `shift` strobe.
- Top level: FSM, bit/byte counters, compare logic and `error` flag.

## Test plan
- BS_BITS=16, no verify, bytes 0xA5, 0x3C back-to-back:
  - `cfg_bit` over 16 consecutive `cfg_en` cycles = 1010010100111100;
  - a behavioural chain model ends holding that sequence;
  - `done` pulses once, at cycle 18 after `start`.
- BS_BITS=16, verify=1, same bytes sent twice to a correct chain model → 32 shifts, `error`=0, one `done`.
- Verify pass with the second byte sent as 0x3D → `error` goes to 1 after the final-bit shift, stays set after `done`, and clears on the next `start`.
- Host inserts 5 idle cycles between bytes → `cfg_en` is 0 during the gap, the bit count is unaffected, and the chain result equals the gap-free case.
- `reset` asserted at shift 7 of LOAD → the next cycle has every output at 0 and state IDLE. A following full load completes correctly.
- `start` during LOAD is ignored. The third `in_valid` byte in a 16-bit pass sees `in_ready`=0.

Source files
------------

// File: rtl/bs_cfg_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
package bs_cfg_pkg;

   // Width of one configuration byte on the host stream.
   localparam int BS_BYTE_W = 8;

   // Loader pass states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      VERIFY = 2'd2
   } bs_state_t;

   // Counter width able to hold the values 0..bits inclusive.
   function automatic int bs_cnt_w(input int bits);
      return $clog2(bits + 1);
   endfunction

endpackage

// File: rtl/bs_byte_serializer.sv
// Byte-to-bit serializer for the configuration chain: one holding register in
// front of an 8-bit MSB-first shift register, driving registered chain pins.
//
// Handshake: a byte transfers on a rising edge where i_in_valid and o_in_ready
// are both high. o_in_ready depends only on internal state, never on
// i_in_valid; the host may hold i_in_valid and i_in_data until it sees the
// transfer.
module bs_byte_serializer
   import bs_cfg_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_active,
   input  logic                 i_quota_ok,
   input  logic [BS_BYTE_W-1:0] i_in_data,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   output logic                 o_accept,
   output logic                 o_cfg_en,
   output logic                 o_cfg_bit,
   output logic                 o_shift
);

   logic [BS_BYTE_W-1:0] r_hold_data;
   logic                 r_hold_full;
   logic [BS_BYTE_W-1:0] r_sh_data;   // bits still to be shifted, MSB next
   logic [2:0]           r_sh_cnt;    // number of bits left in r_sh_data
   logic                 r_cfg_en;
   logic                 r_cfg_bit;

   logic                 w_in_ready;
   logic                 w_accept;
   logic                 w_sh_busy;
   logic [BS_BYTE_W-1:0] w_src;

   assign w_in_ready = i_active && !r_hold_full && i_quota_ok;
   assign w_accept   = w_in_ready && i_in_valid;
   assign w_sh_busy  = (r_sh_cnt != 3'd0);
   // A waiting byte in the holding register has priority; otherwise a byte
   // arriving this cycle bypasses the holding register straight into the
   // shifter so its MSB reaches the chain on the very next cycle.
   assign w_src      = r_hold_full ? r_hold_data : i_in_data;

   // Shift one bit per cycle, reloading from the holding register (or the
   // incoming byte) on the cycle the current byte's last bit is on the pins.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_hold_data <= '0;
         r_hold_full <= 1'b0;
         r_sh_data   <= '0;
         r_sh_cnt    <= 3'd0;
         r_cfg_en    <= 1'b0;
         r_cfg_bit   <= 1'b0;
      end else if (w_sh_busy) begin
         r_cfg_en  <= 1'b1;
         r_cfg_bit <= r_sh_data[BS_BYTE_W-1];
         r_sh_data <= {r_sh_data[BS_BYTE_W-2:0], 1'b0};
         r_sh_cnt  <= r_sh_cnt - 3'd1;
         if (w_accept) begin
            r_hold_data <= i_in_data;
            r_hold_full <= 1'b1;
         end
      end else if (r_hold_full || w_accept) begin
         r_cfg_en    <= 1'b1;
         r_cfg_bit   <= w_src[BS_BYTE_W-1];
         r_sh_data   <= {w_src[BS_BYTE_W-2:0], 1'b0};
         r_sh_cnt    <= 3'd7;
         r_hold_full <= 1'b0;
      end else begin
         // Starved: chain holds until a byte shows up.
         r_cfg_en <= 1'b0;
      end
   end

   assign o_in_ready = w_in_ready;
   assign o_accept   = w_accept;
   assign o_cfg_en   = r_cfg_en;
   assign o_cfg_bit  = r_cfg_bit;
   assign o_shift    = r_cfg_en;   // the chain shifts on every cycle cfg_en is high

endmodule

// File: rtl/bs_config_loader.sv
// Host-side configuration chain loader: streams BS_BITS bits into the chain
// and optionally re-streams them while comparing the bits that fall out.
module bs_config_loader
   import bs_cfg_pkg::*;
#(
   parameter int BS_BITS = 256
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic                 i_verify,
   input  logic [BS_BYTE_W-1:0] i_in_data,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   output logic                 o_cfg_en,
   output logic                 o_cfg_bit,
   input  logic                 i_cfg_ret,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_error,
   output logic [1:0]           o_state
);

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_LOAD   = LOAD;
   localparam logic [1:0] ST_VERIFY = VERIFY;

   localparam int NBYTES     = BS_BITS / BS_BYTE_W;
   localparam int CNT_W      = bs_cnt_w(BS_BITS);
   localparam int BYTE_CNT_W = bs_cnt_w(2 * NBYTES);

   localparam logic [CNT_W-1:0]      LAST_SHIFT = CNT_W'(BS_BITS - 1);
   localparam logic [CNT_W-1:0]      BIT_MAX    = CNT_W'(BS_BITS);
   localparam logic [BYTE_CNT_W-1:0] QUOTA_ONE  = BYTE_CNT_W'(NBYTES);
   localparam logic [BYTE_CNT_W-1:0] QUOTA_TWO  = BYTE_CNT_W'(2 * NBYTES);

   logic [1:0]            r_state;
   logic                  r_verify;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [BYTE_CNT_W-1:0] r_byte_cnt;
   logic                  r_done;
   logic                  r_error;

   logic w_busy;
   logic w_quota_ok;
   logic w_accept;
   logic w_shift;
   logic w_cfg_bit;

   assign w_busy = (r_state != ST_IDLE);

   // The byte count runs across both passes of a verified load, so the first
   // VERIFY byte may be buffered while LOAD's last byte is still shifting and
   // the chain sees no gap between the passes. Each pass still takes exactly
   // BS_BITS/8 bytes.
   assign w_quota_ok = r_verify ? (r_byte_cnt < QUOTA_TWO)
                                : (r_byte_cnt < QUOTA_ONE);

   bs_byte_serializer u_ser (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_active   (w_busy),
      .i_quota_ok (w_quota_ok),
      .i_in_data  (i_in_data),
      .i_in_valid (i_in_valid),
      .o_in_ready (o_in_ready),
      .o_accept   (w_accept),
      .o_cfg_en   (o_cfg_en),
      .o_cfg_bit  (w_cfg_bit),
      .o_shift    (w_shift)
   );

   assign o_cfg_bit = w_cfg_bit;

   // Pass sequencing, shift/byte counting, verify compare and done pulse.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_verify   <= 1'b0;
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_verify   <= i_verify;
                  r_error    <= 1'b0;
                  r_bit_cnt  <= '0;
                  r_byte_cnt <= '0;
                  r_state    <= ST_LOAD;
               end
            end
            ST_LOAD, ST_VERIFY: begin
               if (w_accept) begin
                  r_byte_cnt <= r_byte_cnt + 1'b1;
               end
               if (w_shift) begin
                  // The chain is BS_BITS deep, so the bit falling out now is
                  // the one LOAD shifted in at the same position.
                  if ((r_state == ST_VERIFY) && (i_cfg_ret != w_cfg_bit)) begin
                     r_error <= 1'b1;
                  end
                  if (r_bit_cnt == LAST_SHIFT) begin
                     r_bit_cnt <= '0;
                     if ((r_state == ST_LOAD) && r_verify) begin
                        r_state <= ST_VERIFY;
                     end else begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                     end
                  end else if (r_bit_cnt != BIT_MAX) begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_busy  = w_busy;
   assign o_done  = r_done;
   assign o_error = r_error;
   assign o_state = r_state;

endmodule
